// File: rtl/branch_info_queue_pkg.sv
// Shared branch predictor types: counter encoding and queue entry layout.
// Imported by the branch info queue and predictor-side logic.
package branch_info_queue_pkg;

  localparam int PC_W = 10;

  typedef logic [1:0] ctr_t;

  localparam ctr_t STRONG_NT = 2'b00;
  localparam ctr_t WEAK_NT   = 2'b01;
  localparam ctr_t WEAK_T    = 2'b10;
  localparam ctr_t STRONG_T  = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    ctr_t            ctr;
    logic            taken;
    logic            resolved;
  } bq_entry_t;

endpackage

// File: rtl/branch_info_queue.sv
// In-order in-flight branch queue: alloc at predict, resolve at execute,
// retire head into predictor update ports; flags mispredicts, supports squash.
// Ports: Alloc* (enqueue), Resolve* (outcome), Flush* (squash younger),
// CommitedBranchPC/BranchTaken/BranchCounter/CounterUpdate (retire), Count.
module branch_info_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 10,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       AllocValid,
  input  logic [PC_W-1:0]            AllocPC,
  input  logic [1:0]                 AllocCounter,
  output logic                       AllocReady,
  output logic [TAG_W-1:0]           AllocTag,
  input  logic                       ResolveValid,
  input  logic [TAG_W-1:0]           ResolveTag,
  input  logic                       ResolveTaken,
  output logic                       Mispredict,
  output logic [TAG_W-1:0]           MispredictTag,
  input  logic                       FlushValid,
  input  logic [TAG_W-1:0]           FlushTag,
  output logic [PC_W-1:0]            CommitedBranchPC,
  output logic                       BranchTaken,
  output logic [1:0]                 BranchCounter,
  output logic                       CounterUpdate,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  import branch_info_queue_pkg::*;

  logic [PC_W-1:0] pc_q       [DEPTH];
  ctr_t            ctr_q      [DEPTH];
  logic            taken_q    [DEPTH];
  logic            resolved_q [DEPTH];

  logic [TAG_W:0]   head, tail, cnt, tail_f;
  logic [TAG_W-1:0] hidx, tidx;
  logic             flush_hit, res_ok, accept, has;

  // Age of a tag relative to the head, modulo DEPTH.
  function automatic logic [TAG_W-1:0] tag_off(
    input logic [TAG_W-1:0] tag,
    input logic [TAG_W:0]   h
  );
    return tag - h[TAG_W-1:0];
  endfunction

  function automatic logic occupied(
    input logic [TAG_W-1:0] tag,
    input logic [TAG_W:0]   h,
    input logic [TAG_W:0]   t
  );
    logic [TAG_W:0] n;
    n = t - h;
    return {1'b0, tag_off(tag, h)} < n;
  endfunction

  assign hidx = head[TAG_W-1:0];
  assign tidx = tail[TAG_W-1:0];
  assign cnt  = tail - head;
  assign has  = (cnt != '0);

  assign flush_hit = FlushValid & occupied(FlushTag, head, tail);

  // Flush keeps everything up to and including FlushTag.
  assign tail_f = flush_hit
                ? head + {1'b0, tag_off(FlushTag, head)} + (TAG_W+1)'(1)
                : tail;

  // Resolve is judged against the post-flush tail so squashed
  // entries cannot be resolved in the flush cycle.
  assign res_ok = ResolveValid
                & occupied(ResolveTag, head, tail_f)
                & ~resolved_q[ResolveTag];

  assign AllocReady = (cnt < (TAG_W+1)'(DEPTH)) & ~FlushValid;
  assign accept     = AllocValid & AllocReady;
  assign AllocTag   = tidx;

  assign CounterUpdate    = has & resolved_q[hidx];
  assign CommitedBranchPC = has ? pc_q[hidx]    : '0;
  assign BranchCounter    = has ? ctr_q[hidx]   : '0;
  assign BranchTaken      = has ? taken_q[hidx] : 1'b0;
  assign Count            = cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head          <= '0;
      tail          <= '0;
      Mispredict    <= 1'b0;
      MispredictTag <= '0;
      for (int i = 0; i < DEPTH; i++) resolved_q[i] <= 1'b0;
    end else begin
      if (CounterUpdate) begin
        head             <= head + (TAG_W+1)'(1);
        resolved_q[hidx] <= 1'b0;
      end
      if (accept) begin
        tail             <= tail + (TAG_W+1)'(1);
        resolved_q[tidx] <= 1'b0;
      end else begin
        tail <= tail_f;
      end
      if (res_ok) begin
        resolved_q[ResolveTag] <= 1'b1;
        MispredictTag          <= ResolveTag;
      end
      Mispredict <= res_ok & (ResolveTaken != ctr_q[ResolveTag][1]);
    end
  end

  // Payload needs no reset: it is only visible through occupied slots.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[tidx]    <= AllocPC;
      ctr_q[tidx]   <= AllocCounter;
      taken_q[tidx] <= 1'b0;
    end
    if (res_ok) taken_q[ResolveTag] <= ResolveTaken;
  end

endmodule

// File: doc/branch_info_queue.md
# branch_info_queue

In-order queue that tracks every predicted, in-flight branch from prediction to commit and drives the update side of the local 2-bit-counter predictor. Each entry records the branch PC (10-bit table index) and the counter value read at prediction time. Execute fills in the resolved outcome, and entries retire in program order into the predictor's `CommitedBranchPC`/`BranchTaken`/`BranchCounter`/`CounterUpdate` inputs. It also flags mispredictions and supports squash of younger entries.

## Interface
- `DEPTH`, 8: entry count; power of two, ≥2.
- `PC_W`, 10: predictor index width.
- `TAG_W`, $clog2(DEPTH): entry tag width.

- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `AllocValid` in 1: predict stage requests an entry.
- `AllocPC` in PC_W: predicted branch index.
- `AllocCounter` in 2: counter value used for the prediction.
- `AllocReady` out 1: entry accepted this cycle when high together with `AllocValid`.
- `AllocTag` out TAG_W: tag of the entry written on acceptance (tail index).
- `ResolveValid` in 1: execute reports an outcome.
- `ResolveTag` in TAG_W: entry being resolved.
- `ResolveTaken` in 1: actual direction.
- `Mispredict` out 1: registered; resolved direction ≠ `AllocCounter[1]` of that entry.
- `MispredictTag` out TAG_W: registered tag for `Mispredict`.
- `FlushValid` in 1: squash all entries younger than `FlushTag`.
- `FlushTag` in TAG_W: youngest surviving entry.
- `CommitedBranchPC` out PC_W: head PC.
- `BranchTaken` out 1: head resolved direction.
- `BranchCounter` out 2: head stored counter.
- `CounterUpdate` out 1: head valid and resolved; retires this cycle.
- `Count` out $clog2(DEPTH+1): occupied entries.

## Operation
- Storage: per entry `pc`, `ctr[1:0]`, `taken`, `resolved`. Head/tail pointers are TAG_W+1 bits and carry a wrap bit. `Count = tail − head`.
- Allocation:
  - `AllocReady = (Count < DEPTH) & ~FlushValid`. There is no same-cycle bypass from a commit, so a full queue stays not-ready even while the head retires.
  - On accept, the entry at `tail` is written with `resolved=0` and tail increments.
- Resolve:
  - Applies only if `ResolveTag` is currently occupied (between head and tail after any same-cycle flush), not already resolved, and not squashed in the same cycle.
  - Sets `taken`, `resolved=1`.
  - Next cycle: `Mispredict = (ResolveTaken ≠ ctr[1])`, `MispredictTag = ResolveTag`.
  - Ignored resolves produce `Mispredict=0`.
- Commit:
  - `CounterUpdate = occupied(head) & resolved(head)`, combinational from state.
  - Outputs always show head-entry fields, and are 0 when empty.
  - When `CounterUpdate=1`, head increments at the next edge. The predictor always accepts, so there is no backpressure.
- Flush:
  - If `FlushTag` is occupied: `tail ← head + ((FlushTag − head[TAG_W-1:0]) mod DEPTH) + 1`.
  - If unoccupied: ignored.
  - Same-cycle alloc is blocked. A same-cycle commit of the head proceeds, because the head is never younger than `FlushTag`. If `FlushTag == head` and the head commits, the queue becomes empty.
- Simultaneous alloc + commit: both apply, `Count` unchanged.
- Wrap: pointers wrap modulo 2·DEPTH, and tags are the low TAG_W bits.

## Timing
- Reset (asynchronous, `rstn` low) sets:
  - head = tail = 0, all `resolved` = 0;
  - `Mispredict` = 0, `MispredictTag` = 0;
  - therefore `CounterUpdate` = 0, `CommitedBranchPC` = 0, `BranchTaken` = 0, `BranchCounter` = 0, `Count` = 0;
  - `AllocReady` = 1 (when `FlushValid` = 0), `AllocTag` = 0.
- Reset mid-operation discards all entries immediately. No partial commit is emitted.
- Latencies:
  - Alloc → resolvable: next cycle.
  - Resolve → `CounterUpdate` for that head entry: next cycle.
  - Resolve → `Mispredict`: 1 cycle.
- Minimum alloc-to-commit: 2 cycles (alloc edge, resolve edge, commit visible).
- Throughput: 1 alloc and 1 commit per cycle.

## Structure
- Shared predictor package holds:
  - `PC_W`;
  - the 2-bit counter typedef and its constants (`STRONG_NT=00`, `WEAK_NT=01`, `WEAK_T=10`, `STRONG_T=11`);
  - the entry struct {pc, ctr, taken, resolved}.
- Single module, no sub-module. Pointer/occupancy helper functions live inside the module.

## Test plan
- Reset then idle → `Count=0`, `CounterUpdate=0`, `AllocReady=1`, `AllocTag=0`.
- Alloc PC=0x05 ctr=01 → tag 0; resolve tag 0 taken=1 → next cycle `Mispredict=1`, `MispredictTag=0`, `CounterUpdate=1`, `CommitedBranchPC=0x05`, `BranchCounter=01`, `BranchTaken=1`; following cycle `Count=0`.
- Fill 8 entries → `AllocReady=0` at `Count=8`. Resolve tags out of order 3,0,1,2 → commits only start after tag 0 resolves, then retire 0,1,2,3 in consecutive cycles.
- 8 entries, flush `FlushTag=2` with same-cycle alloc → `Count=3`, alloc dropped. Next alloc gets tag 3. Resolve to tag 5 is ignored.
- Wrap: 20 alloc/resolve/commit rounds with 3 in flight → tags cycle 0..7 and `Count` never exceeds 3.
- Assert `rstn` low with 4 entries pending and head resolved → `CounterUpdate` drops to 0 immediately, `Count=0`.
